// File: rtl/mc_control_unit.sv
// mc_control_unit: Moore multicycle main controller driving the 16-bit MIPS datapath.
module mc_control_unit #(
  parameter int OPC_W   = 4,
  parameter int FUNCT_W = 3,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic [2:0]         ALUControl,
  output logic               PCsrc,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal,
  output logic               halted
);
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
    EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, HALT = 11
  } state_t;
  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(15);
  state_t r_state, w_next;
  logic w_pcwrite, w_branch, w_irwrite, w_memwrite, w_regwrite, w_done, w_illegal, w_known;
  assign w_known = opcode == OP_R || opcode == OP_LW || opcode == OP_SW ||
                   opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_HALT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next;
  always_comb begin
    w_next     = FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'b00;
    ALUControl = 3'b010;
    PCsrc      = 1'b0;
    case (r_state)
      FETCH: begin
        w_next    = DECODE;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUsrcB   = 2'b01;
      end
      DECODE: begin
        w_next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                 opcode == OP_R    ? EXECUTE :
                 opcode == OP_BEQ  ? BRANCH  :
                 opcode == OP_ADDI ? ADDIEX  :
                 opcode == OP_HALT ? HALT    : FETCH;
        ALUsrcB   = 2'b11;
        w_illegal = !w_known;
        w_done    = !w_known || opcode == OP_HALT;
      end
      MEMADR: begin
        w_next  = opcode == OP_LW ? MEMRD : MEMWR;
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      MEMRD: begin
        w_next = MEMWB;
        IorD   = 1'b1;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      EXECUTE: begin
        w_next     = ALUWB;
        ALUsrcA    = 1'b1;
        // unknown funct falls back to add so writeback still proceeds
        ALUControl = funct == FUNCT_W'(0) ? 3'b010 :
                     funct == FUNCT_W'(1) ? 3'b110 :
                     funct == FUNCT_W'(2) ? 3'b000 :
                     funct == FUNCT_W'(3) ? 3'b001 :
                     funct == FUNCT_W'(4) ? 3'b111 : 3'b010;
        w_illegal  = funct > FUNCT_W'(4);
      end
      ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      BRANCH: begin
        ALUsrcA    = 1'b1;
        ALUControl = 3'b110;
        PCsrc      = 1'b1;
        w_branch   = 1'b1;
        w_done     = 1'b1;
      end
      ADDIEX: begin
        w_next  = ADDIWB;
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      HALT: w_next = HALT;
      default: w_next = FETCH;
    endcase
  end
  // write enables and status flags are gated by reset so an aborted instruction writes nothing
  assign PCEn       = rst & (w_pcwrite | (w_branch & zero));
  assign IRWrite    = rst & w_irwrite;
  assign MemWrite   = rst & w_memwrite;
  assign RegWrite   = rst & w_regwrite;
  assign instr_done = rst & w_done;
  assign illegal    = rst & w_illegal;
  assign halted     = rst & (r_state == HALT);
  assign state      = r_state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed cycle vectors checked through an expected-output scoreboard queue.
module tb_mc_control_unit;
  logic clk = 1'b0, rst = 1'b0, zero = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] funct = '0;
  logic PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc;
  logic instr_done, illegal, halted;
  logic [1:0] ALUsrcB;
  logic [2:0] ALUControl;
  logic [3:0] state;
  int applied = 0, miscompares = 0;

  mc_control_unit #(.OPC_W(4), .FUNCT_W(3), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .ALUControl(ALUControl), .PCsrc(PCsrc), .state(state),
    .instr_done(instr_done), .illegal(illegal), .halted(halted));

  always #5 clk = ~clk;

  // Layout: state _ PCEn IorD MemWrite IRWrite _ RegDst MemtoReg RegWrite ALUsrcA _ ALUsrcB _ ALUControl _ PCsrc instr_done illegal halted
  localparam logic [20:0] E_RST  = 21'b0000_0000_0000_01_010_0000;
  localparam logic [20:0] E_FET  = 21'b0000_1001_0000_01_010_0000;
  localparam logic [20:0] E_DEC  = 21'b0001_0000_0000_11_010_0000;
  localparam logic [20:0] E_DECI = 21'b0001_0000_0000_11_010_0110;
  localparam logic [20:0] E_DECH = 21'b0001_0000_0000_11_010_0100;
  localparam logic [20:0] E_MADR = 21'b0010_0000_0001_10_010_0000;
  localparam logic [20:0] E_MRD  = 21'b0011_0100_0000_00_010_0000;
  localparam logic [20:0] E_MWB  = 21'b0100_0000_0110_00_010_0100;
  localparam logic [20:0] E_MWR  = 21'b0101_0110_0000_00_010_0100;
  localparam logic [20:0] E_EXS  = 21'b0110_0000_0001_00_110_0000;
  localparam logic [20:0] E_EXI  = 21'b0110_0000_0001_00_010_0010;
  localparam logic [20:0] E_AWB  = 21'b0111_0000_1010_00_010_0100;
  localparam logic [20:0] E_BR1  = 21'b1000_1000_0001_00_110_1100;
  localparam logic [20:0] E_BR0  = 21'b1000_0000_0001_00_110_1100;
  localparam logic [20:0] E_AEX  = 21'b1001_0000_0001_10_010_0000;
  localparam logic [20:0] E_AWB2 = 21'b1010_0000_0010_00_010_0100;
  localparam logic [20:0] E_HLT  = 21'b1011_0000_0000_00_010_0001;

  typedef struct { logic [20:0] exp; int id; } item_t;
  item_t sb[$];
  int vec_id = 0;

  function automatic logic [20:0] got();
    return {state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA,
            ALUsrcB, ALUControl, PCsrc, instr_done, illegal, halted};
  endfunction

  task automatic step(input logic r, input logic [3:0] op, input logic [2:0] fn,
                      input logic z, input logic [20:0] e);
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct = fn; zero = z;
    sb.push_back('{e, vec_id});
    vec_id++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      logic [20:0] g;
      it = sb.pop_front();
      g = got();
      applied++;
      if (g !== it.exp) begin
        miscompares++;
        $display("FAIL vec%0d: got %b required %b", it.id, g, it.exp);
      end
    end
  end

  initial begin
    step(0, 4'h0, 3'd0, 0, E_RST);
    step(0, 4'h0, 3'd0, 0, E_RST);
    // R-type sub
    step(1, 4'h0, 3'd1, 0, E_FET);
    step(1, 4'h0, 3'd1, 0, E_DEC);
    step(1, 4'h0, 3'd1, 0, E_EXS);
    step(1, 4'h0, 3'd1, 0, E_AWB);
    // LW
    step(1, 4'h1, 3'd0, 0, E_FET);
    step(1, 4'h1, 3'd0, 0, E_DEC);
    step(1, 4'h1, 3'd0, 0, E_MADR);
    step(1, 4'h1, 3'd0, 0, E_MRD);
    step(1, 4'h1, 3'd0, 0, E_MWB);
    // SW
    step(1, 4'h2, 3'd0, 0, E_FET);
    step(1, 4'h2, 3'd0, 0, E_DEC);
    step(1, 4'h2, 3'd0, 0, E_MADR);
    step(1, 4'h2, 3'd0, 0, E_MWR);
    // BEQ taken, zero high in DECODE must not enable PC
    step(1, 4'h3, 3'd0, 1, E_FET);
    step(1, 4'h3, 3'd0, 1, E_DEC);
    step(1, 4'h3, 3'd0, 1, E_BR1);
    // BEQ not taken
    step(1, 4'h3, 3'd0, 0, E_FET);
    step(1, 4'h3, 3'd0, 0, E_DEC);
    step(1, 4'h3, 3'd0, 0, E_BR0);
    // ADDI
    step(1, 4'h4, 3'd0, 0, E_FET);
    step(1, 4'h4, 3'd0, 0, E_DEC);
    step(1, 4'h4, 3'd0, 0, E_AEX);
    step(1, 4'h4, 3'd0, 0, E_AWB2);
    // illegal opcode
    step(1, 4'h7, 3'd0, 0, E_FET);
    step(1, 4'h7, 3'd0, 0, E_DECI);
    // illegal funct
    step(1, 4'h0, 3'd6, 0, E_FET);
    step(1, 4'h0, 3'd6, 0, E_DEC);
    step(1, 4'h0, 3'd6, 0, E_EXI);
    step(1, 4'h0, 3'd6, 0, E_AWB);
    // LW aborted by async reset in MEMRD
    step(1, 4'h1, 3'd0, 0, E_FET);
    step(1, 4'h1, 3'd0, 0, E_DEC);
    step(1, 4'h1, 3'd0, 0, E_MADR);
    step(1, 4'h1, 3'd0, 0, E_MRD);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    applied++;
    if (got() !== E_RST) begin
      miscompares++;
      $display("FAIL async_rst: got %b required %b", got(), E_RST);
    end
    step(0, 4'h1, 3'd0, 0, E_RST);
    step(1, 4'h1, 3'd0, 0, E_FET);
    // HALT
    step(1, 4'hf, 3'd0, 0, E_DECH);
    for (int i = 0; i < 20; i++) step(1, 4'hf, 3'd0, 1, E_HLT);
    step(0, 4'hf, 3'd0, 0, E_RST);
    step(1, 4'h0, 3'd0, 0, E_FET);
    step(1, 4'h0, 3'd0, 0, E_DEC);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Moore-style multicycle main controller for the 16-bit MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback by driving every datapath control input: PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, ALUsrcB, ALUControl, PCsrc.
- Takes opcode/funct from the datapath instruction register and the ALU zero flag.
- Sits beside dataPath at the processor top level.

Parameters:
- OPC_W, 4, opcode width (instr[15:12]).
- FUNCT_W, 3, R-type funct width (instr[2:0]).
- STATE_W, 4, state register width (exported on state port).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OPC_W  IR opcode field.
- funct  in  FUNCT_W  IR funct field.
- zero  in  1  ALU zero flag.
- PCEn  out  1  PC register enable.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  IR load enable.
- RegDst  out  1  write-register select: 0=rt, 1=rd.
- MemtoReg  out  1  write-data select: 0=ALUOut, 1=MDR.
- RegWrite  out  1  register file write enable.
- ALUsrcA  out  1  ALU A select: 0=PC, 1=A reg.
- ALUsrcB  out  2  ALU B select: 00=B reg, 01=const 2, 10=sext imm, 11=sext imm<<1.
- ALUControl  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCsrc  out  1  next-PC select: 0=ALU result, 1=ALUOut.
- state  out  STATE_W  current state (debug).
- instr_done  out  1  1-cycle pulse in an instruction's final state.
- illegal  out  1  pulse on unknown opcode or funct.
- halted  out  1  high while in HALT.

Behaviour:
- Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 1111 HALT; all others are illegal.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, HALT=11.
- Transitions:
  - FETCH->DECODE.
  - DECODE->MEMADR (LW/SW), EXECUTE (R), BRANCH (BEQ), ADDIEX (ADDI), HALT (1111), FETCH (illegal).
  - MEMADR->MEMRD (LW) / MEMWR (SW); MEMRD->MEMWB.
  - EXECUTE->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB->FETCH.
  - HALT->HALT until reset.
  - Codes 12-15->FETCH.
- Cycle counts: LW 5, SW/R/ADDI 4, BEQ 3, illegal 2.
- Output defaults: all 1-bit outputs 0, ALUsrcB=00, ALUControl=010. Only deviations are listed below.
- Per-state outputs:
  - FETCH: IRWrite=1, ALUsrcB=01, PCWrite=1 (PC <- PC+2).
  - DECODE: ALUsrcB=11 (branch target into ALUOut).
  - MEMADR: ALUsrcA=1, ALUsrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUsrcA=1, ALUControl=decode(funct).
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUsrcA=1, ALUControl=110, PCsrc=1, Branch=1.
  - ADDIEX: ALUsrcA=1, ALUsrcB=10.
  - ADDIWB: RegWrite=1.
- PCEn = PCWrite | (Branch & zero), combinational; zero is sampled in the BRANCH cycle only.
- funct decode: 000->010, 001->110, 010->000, 011->001, 100->111. Values 101-111 give ALUControl=010 with illegal=1 in EXECUTE; writeback still proceeds.
- illegal is also pulsed in DECODE for an unknown opcode.
- instr_done is high in MEMWB, MEMWR, ALUWB, BRANCH and ADDIWB, and in DECODE when the opcode is illegal or HALT.
- halted = (state==HALT). In HALT all enables are 0.
- Reset: rst=0 asynchronously forces state=FETCH. While rst=0, PCEn, IRWrite, MemWrite and RegWrite are forced 0 combinationally, and instr_done, illegal and halted are forced 0. Reset mid-instruction aborts it with no further writes.
- The first FETCH enables assert in the first cycle after rst rises.
- opcode/funct are used only in DECODE/MEMADR/EXECUTE; they are otherwise don't-care.

Test Plan:
- Reset then R-type (opcode 0000, funct 001) -> states 0,1,6,7,0; ALUControl=110 in EXECUTE; RegDst=1 and RegWrite=1 only in ALUWB; instr_done pulse at ALUWB.
- LW then SW -> LW: 0,1,2,3,4 with IorD=1 in MEMRD and MemtoReg=RegWrite=1 in MEMWB. SW: 0,1,2,5 with MemWrite=1 exactly one cycle.
- BEQ with zero=1 -> PCEn=1, PCsrc=1 in BRANCH. Repeat with zero=0 -> PCEn=0 in BRANCH. Both return to FETCH after 3 cycles.
- Opcode 0111 -> illegal and instr_done pulse in DECODE, then FETCH. Funct 110 -> illegal in EXECUTE, ALUControl=010.
- Opcode 1111 -> state 11, halted=1, all enables 0 for 20 cycles; rst low then high -> FETCH with IRWrite=1.
- Assert rst mid-LW (state 3) asynchronously -> state=0 immediately and no RegWrite pulse; after release, normal fetch.
